// File: rtl/bp_scoreboard.sv
// rtl/bp_scoreboard.sv - forwarding/hazard controller with a shift-register scoreboard of in-flight writes
module bp_scoreboard #(
    parameter int AW    = 5,
    parameter int NRP   = 2,
    parameter int DEPTH = 3,
    parameter int SW    = $clog2(DEPTH+1),
    parameter int CW    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [AW-1:0]     id_rd,
    input  logic              id_we,
    input  logic              id_load,
    input  logic              id_label,
    input  logic              flush,
    input  logic [NRP-1:0]    rs_en,
    input  logic [NRP*AW-1:0] rs_addr,
    input  logic [NRP-1:0]    rf_label,
    output logic [NRP*SW-1:0] bp_sel,
    output logic [NRP-1:0]    bp_label,
    output logic              stall,
    output logic [CW-1:0]     stall_cnt
);

    // Index k-1 holds pipeline stage k (index 0 = EX).
    logic [DEPTH-1:0]         sb_v;
    logic [DEPTH-1:0]         sb_load;
    logic [DEPTH-1:0]         sb_label;
    logic [DEPTH-1:0][AW-1:0] sb_rd;

    logic ins_v;
    assign ins_v = id_valid & id_we & (id_rd != '0);

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        bp_sel   = '0;
        bp_label = rf_label;
        stall    = 1'b0;
        for (int p = 0; p < NRP; p++) begin
            if (rs_en[p] && (rs_addr[p*AW +: AW] != '0)) begin
                for (int k = DEPTH-1; k >= 0; k--) begin
                    if (sb_v[k] && (sb_rd[k] == rs_addr[p*AW +: AW])) begin
                        bp_sel[p*SW +: SW] = SW'(k+1);
                        bp_label[p]        = sb_label[k];
                    end
                end
                if (sb_v[0] && sb_load[0] && (sb_rd[0] == rs_addr[p*AW +: AW]))
                    stall = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_v      <= '0;
            sb_load   <= '0;
            sb_label  <= '0;
            sb_rd     <= '0;
            stall_cnt <= '0;
        end else begin
            for (int k = DEPTH-1; k >= 1; k--) begin
                sb_v[k]     <= sb_v[k-1];
                sb_load[k]  <= sb_load[k-1];
                sb_label[k] <= sb_label[k-1];
                sb_rd[k]    <= sb_rd[k-1];
            end
            // A flush squashes both the instruction entering EX and the one already in EX.
            sb_v[1]     <= sb_v[0] & ~flush;
            sb_v[0]     <= ins_v & ~stall & ~flush;
            sb_load[0]  <= id_load;
            sb_label[0] <= id_label;
            sb_rd[0]    <= id_rd;
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_bp_scoreboard.sv
// tb/tb_bp_scoreboard.sv - directed self-checking bench for bp_scoreboard
module tb_bp_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rd;
    logic        id_we;
    logic        id_load;
    logic        id_label;
    logic        flush;
    logic [1:0]  rs_en;
    logic [9:0]  rs_addr;
    logic [1:0]  rf_label;
    logic [3:0]  bp_sel;
    logic [1:0]  bp_label;
    logic        stall;
    logic [2:0]  stall_cnt;

    int checks   = 0;
    int failures = 0;

    bp_scoreboard #(.AW(5), .NRP(2), .DEPTH(3), .CW(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .id_valid (id_valid),
        .id_rd    (id_rd),
        .id_we    (id_we),
        .id_load  (id_load),
        .id_label (id_label),
        .flush    (flush),
        .rs_en    (rs_en),
        .rs_addr  (rs_addr),
        .rf_label (rf_label),
        .bp_sel   (bp_sel),
        .bp_label (bp_label),
        .stall    (stall),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic ld, input logic lbl);
        id_valid = 1'b1;
        id_we    = 1'b1;
        id_rd    = rd;
        id_load  = ld;
        id_label = lbl;
    endtask

    task automatic idle();
        id_valid = 1'b0;
        id_we    = 1'b0;
        id_rd    = 5'd0;
        id_load  = 1'b0;
        id_label = 1'b0;
        flush    = 1'b0;
        rs_en    = 2'b00;
    endtask

    initial begin
        // 1. reset
        rst_n    = 1'b0;
        idle();
        rs_en    = 2'b11;
        rs_addr  = {5'd3, 5'd3};
        rf_label = 2'b10;
        #1;
        chk("rst_sel",   32'(bp_sel),    32'h0);
        chk("rst_label", 32'(bp_label),  32'h2);
        chk("rst_stall", 32'(stall),     32'h0);
        chk("rst_cnt",   32'(stall_cnt), 32'h0);
        #1 rst_n = 1'b1;
        tick();
        chk("rst_nofwd", 32'(bp_sel), 32'h0);

        // 2. stage walk of r5 (label 1)
        idle();
        issue(5'd5, 1'b0, 1'b1);
        tick();
        idle();
        rs_en    = 2'b01;
        rs_addr  = {5'd0, 5'd5};
        rf_label = 2'b00;
        #1;
        chk("walk_s1_sel", 32'(bp_sel), 32'h1);
        chk("walk_s1_lbl", 32'(bp_label), 32'h1);
        tick();
        chk("walk_s2_sel", 32'(bp_sel), 32'h2);
        chk("walk_s2_lbl", 32'(bp_label), 32'h1);
        tick();
        chk("walk_s3_sel", 32'(bp_sel), 32'h3);
        chk("walk_s3_lbl", 32'(bp_label), 32'h1);
        tick();
        chk("walk_gone_sel", 32'(bp_sel), 32'h0);
        chk("walk_gone_lbl", 32'(bp_label), 32'h0);

        // 3. priority: r7 (label 0) in stage 3, r7 (label 1) in stage 1
        idle();
        issue(5'd7, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        issue(5'd7, 1'b0, 1'b1);
        tick();
        idle();
        rs_en    = 2'b11;
        rs_addr  = {5'd0, 5'd7};
        rf_label = 2'b00;
        issue(5'd0, 1'b0, 1'b1);
        #1;
        chk("prio_sel",   32'(bp_sel), 32'h1);
        chk("prio_lbl",   32'(bp_label), 32'h1);
        chk("prio_stall", 32'(stall), 32'h0);
        tick();
        idle();
        rs_en   = 2'b01;
        rs_addr = {5'd0, 5'd7};
        #1;
        chk("r0_skip_sel", 32'(bp_sel), 32'h2);

        // 4. load-use
        idle();
        tick(); tick(); tick();
        issue(5'd9, 1'b1, 1'b0);
        #1;
        chk("lu_nostall", 32'(stall), 32'h0);
        tick();
        issue(5'd10, 1'b0, 1'b0);
        rs_en   = 2'b10;
        rs_addr = {5'd9, 5'd0};
        #1;
        chk("lu_stall",     32'(stall), 32'h1);
        chk("lu_stall_sel", 32'(bp_sel), 32'h4);
        tick();
        rs_en   = 2'b11;
        rs_addr = {5'd9, 5'd10};
        #1;
        chk("lu_release", 32'(stall), 32'h0);
        chk("lu_sel_s2",  32'(bp_sel), 32'h8);
        chk("lu_cnt",     32'(stall_cnt), 32'h1);
        tick();

        // 5. flush together with a load-use stall
        idle();
        tick(); tick(); tick();
        issue(5'd2, 1'b1, 1'b0);
        tick();
        issue(5'd11, 1'b0, 1'b0);
        rs_en   = 2'b01;
        rs_addr = {5'd0, 5'd2};
        flush   = 1'b1;
        #1;
        chk("fl_stall", 32'(stall), 32'h1);
        tick();
        idle();
        rs_en   = 2'b01;
        rs_addr = {5'd0, 5'd2};
        #1;
        chk("fl_squash_sel", 32'(bp_sel), 32'h0);
        chk("fl_squash_stall", 32'(stall), 32'h0);
        chk("fl_cnt", 32'(stall_cnt), 32'h2);

        // 6. counter saturation at 3 bits, then async reset mid-stall
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        chk("sat_cleared", 32'(stall_cnt), 32'h0);
        for (int i = 0; i < 9; i++) begin
            idle();
            issue(5'd9, 1'b1, 1'b0);
            tick();
            issue(5'd12, 1'b0, 1'b0);
            rs_en   = 2'b10;
            rs_addr = {5'd9, 5'd0};
            #1;
            chk("sat_stall", 32'(stall), 32'h1);
            tick();
            chk("sat_cnt", 32'(stall_cnt), (i + 1 > 7) ? 32'd7 : 32'(i + 1));
        end
        chk("sat_final", 32'(stall_cnt), 32'h7);
        idle();
        issue(5'd9, 1'b1, 1'b0);
        tick();
        issue(5'd12, 1'b0, 1'b0);
        rs_en   = 2'b10;
        rs_addr = {5'd9, 5'd0};
        #1;
        chk("arst_pre_stall", 32'(stall), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_stall", 32'(stall), 32'h0);
        chk("arst_cnt",   32'(stall_cnt), 32'h0);
        chk("arst_sel",   32'(bp_sel), 32'h0);
        #1 rst_n = 1'b1;
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
